reg_wb_scoreboard: RTL and testbench
====================================

# reg_wb_scoreboard

Parametrised register-file write-enable decoder with an integrated pending-write scoreboard. It sits between issue/writeback control and the register file.
- Decodes the writeback destination index into a registered one-hot write-enable vector.
- Tracks which registers have an in-flight write.
- Stalls issue on RAW/WAW hazards through a ready handshake.
- Generalises the fixed 5-to-32 write decoder to any register count and adds hazard tracking.

## Interface
- ADDR_W, 5, width of register index ports
- NREG, 32, number of registers; legal range 2..2**ADDR_W
- ZERO_HARDWIRED, 1, when 1 register 0 is never written and never marked pending
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset; sampled on clock rising edge
- iss_valid  in  1  issue request present
- iss_rd  in  ADDR_W  destination register of issuing instruction
- iss_rs1  in  ADDR_W  first source register
- iss_rs2  in  ADDR_W  second source register
- iss_ready  out  1  issue may proceed this cycle (combinational)
- wb_valid  in  1  writeback present this cycle
- wb_rd  in  ADDR_W  writeback destination register
- wen  out  NREG  registered one-hot register-file write enable
- pending  out  NREG  scoreboard bit per register; 1 means a write is in flight
- err  out  1  sticky protocol error flag

## Operation
- Issue handshake:
  - iss_ready is 1 when none of pending[iss_rs1], pending[iss_rs2] or pending[iss_rd] is set.
  - Any index >= NREG counts as not pending.
  - iss_ready does not depend on iss_valid.
  - An issue is accepted when iss_valid && iss_ready.
- Accepted issue sets pending[iss_rd], except:
  - iss_rd == 0 with ZERO_HARDWIRED=1;
  - iss_rd >= NREG, which sets err instead.
- Writeback:
  - wb_valid with wb_rd < NREG clears pending[wb_rd].
  - It also drives wen[wb_rd]=1 for exactly one cycle.
  - With wb_rd == 0 and ZERO_HARDWIRED=1: wen stays all-zero and no error is raised.
- Error conditions:
  - wb_valid with wb_rd >= NREG: wen stays all-zero and err is set.
  - wb_valid to a register whose pending bit is 0 (register 0 excluded when hardwired): err is set, but wen still pulses.
- err stays 1 until reset.
- Simultaneous accepted issue and writeback to the same register: the clear applies first, then the set, so pending remains 1 and wen pulses. This case is only reachable with the bypass feature.
- Simultaneous events to different registers are independent.
- wen has at most one bit set in any cycle.

## Timing
- Reset values: wen = 0, pending = 0, err = 0.
- During reset:
  - iss_ready evaluates from the zero scoreboard, so it is 1.
  - Issues and writebacks are ignored.
- Reset mid-operation discards all pending bits on the next edge; no wen pulse is produced for a writeback sampled in the reset cycle.
- wen latency: wb_valid sampled at edge N gives wen high during cycle N+1 and low at N+2, unless another writeback arrives.
- pending latency:
  - updates at the edge where the issue or writeback is sampled;
  - visible on pending and iss_ready in the following cycle.
- Back-to-back writebacks to different registers produce back-to-back single-bit wen pulses.
- iss_ready is purely combinational from pending and the iss_* indices; with the bypass feature it also depends on the wb_* inputs.

## Configuration
- SB_WB_BYPASS_EN defined:
  - iss_ready evaluates against pending with the same-cycle writeback already cleared (pending & ~onehot(wb_rd) when wb_valid).
  - A dependent instruction can therefore issue in the writeback cycle.
- SB_WB_BYPASS_EN undefined:
  - iss_ready uses registered pending only.
  - A dependent instruction issues one cycle after the writeback edge.
  - Same-register issue plus writeback in one cycle is impossible.

## Test plan
- Reset, then wb_valid=1, wb_rd=5 with nothing pending:
  - wen = 32'h0000_0020 for one cycle;
  - err = 1.
- Issue iss_rd=7, iss_rs1=1, iss_rs2=2:
  - pending[7]=1 next cycle;
  - a following issue with iss_rs1=7 sees iss_ready=0;
  - after wb_rd=7, pending[7]=0 and iss_ready=1 one cycle later (no bypass), or in the same cycle (bypass).
- Issue iss_rd=0 with ZERO_HARDWIRED=1, then wb_rd=0: pending stays 0, wen stays 0, err stays 0.
- NREG=24, wb_valid with wb_rd=30: wen stays 0 and err=1.
- Walk wb_rd over 0..NREG-1 after issuing every register:
  - each wen is exactly one-hot at the decoded index, 1 cycle after the writeback;
  - the pending vector ends at 0.
- Set pending[3] and pending[9], then assert reset_n=0 for one edge together with wb_rd=3:
  - pending = 0, wen = 0, err = 0.

Source files
------------

// File: rtl/reg_wb_scoreboard.sv
// Register-file write-enable decoder with a pending-write scoreboard and RAW/WAW issue stall.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle writeback clear the hazard seen by issue.
module reg_wb_scoreboard #(
    parameter int ADDR_W         = 5,
    parameter int NREG           = 32,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic [NREG-1:0]   wen,
    output logic [NREG-1:0]   pending,
    output logic              err
);

    // Register 0 drops out of this mask when it is hardwired to zero.
    localparam logic [NREG-1:0] WRITABLE = ~(NREG'(ZERO_HARDWIRED != 0 ? 1'b1 : 1'b0));

    // Indices at or beyond NREG decode to an all-zero vector.
    function automatic logic [NREG-1:0] decode(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == ADDR_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < (ADDR_W+1)'(NREG));
    endfunction

    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] wb_write;
    logic [NREG-1:0] view;
    logic [NREG-1:0] hazard;
    logic [NREG-1:0] iss_set;
    logic            accept;
    logic            err_set;

    always_comb begin
        wb_hit   = wb_valid ? decode(wb_rd) : '0;
        wb_write = wb_hit & WRITABLE;
`ifdef SB_WB_BYPASS_EN
        view     = pending & ~wb_hit;
`else
        view     = pending;
`endif
        hazard    = view & (decode(iss_rs1) | decode(iss_rs2) | decode(iss_rd));
        iss_ready = ~(|hazard);
        accept    = iss_valid & iss_ready;
        iss_set   = accept ? (decode(iss_rd) & WRITABLE) : '0;

        // Writing a register that has no write in flight is a protocol error.
        err_set = 1'b0;
        if (accept && !in_range(iss_rd)) begin
            err_set = 1'b1;
        end
        if (wb_valid && !in_range(wb_rd)) begin
            err_set = 1'b1;
        end
        if ((|wb_write) && !(|(pending & wb_write))) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
            wen     <= '0;
            err     <= 1'b0;
        end else begin
            pending <= (pending & ~wb_write) | iss_set;
            wen     <= wb_write;
            err     <= err | err_set;
        end
    end

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed self-checking bench for reg_wb_scoreboard (default 32-register and a 24-register instance).
module tb_reg_wb_scoreboard;

    logic        clock;
    logic        reset_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wen;
    logic [31:0] pending;
    logic        err;

    logic        iss_valid24;
    logic [4:0]  iss_rd24;
    logic [4:0]  iss_rs124;
    logic [4:0]  iss_rs224;
    logic        iss_ready24;
    logic        wb_valid24;
    logic [4:0]  wb_rd24;
    logic [23:0] wen24;
    logic [23:0] pending24;
    logic        err24;

    int n_checks;
    int n_fail;

    reg_wb_scoreboard #(.ADDR_W(5), .NREG(32), .ZERO_HARDWIRED(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wen(wen), .pending(pending), .err(err)
    );

    reg_wb_scoreboard #(.ADDR_W(5), .NREG(24), .ZERO_HARDWIRED(1)) dut24 (
        .clock(clock), .reset_n(reset_n),
        .iss_valid(iss_valid24), .iss_rd(iss_rd24), .iss_rs1(iss_rs124), .iss_rs2(iss_rs224),
        .iss_ready(iss_ready24), .wb_valid(wb_valid24), .wb_rd(wb_rd24),
        .wen(wen24), .pending(pending24), .err(err24)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0;
        iss_valid24 = 1'b0; iss_rd24 = 5'd0; iss_rs124 = 5'd0; iss_rs224 = 5'd0;
        wb_valid24 = 1'b0; wb_rd24 = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd6;
        step();
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", iss_ready);
        end
        step();
        n_checks++;
        if (pending !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_pending: got %h expected 0", pending);
        end
        n_checks++;
        if (wen !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_wen: got %h expected 0", wen);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err);
        end
        idle_inputs();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_unpended_wb();
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd5;
        step();
        wb_valid = 1'b0;
        n_checks++;
        if (wen !== 32'h0000_0020) begin
            n_fail++; $display("[TB] FAIL unpended_wen: got %h expected 00000020", wen);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL unpended_err: got %b expected 1", err);
        end
        step();
        step();
        n_checks++;
        if (wen !== 32'h0) begin
            n_fail++; $display("[TB] FAIL unpended_wen_drop: got %h expected 0", wen);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_raw();
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL raw_first_ready: got %b expected 1", iss_ready);
        end
        step();
        iss_rd = 5'd8; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
        #1;
        n_checks++;
        if (pending !== 32'h0000_0080) begin
            n_fail++; $display("[TB] FAIL raw_pending7: got %h expected 00000080", pending);
        end
        n_checks++;
        if (iss_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL raw_stall: got %b expected 0", iss_ready);
        end
        step();
        n_checks++;
        if (pending !== 32'h0000_0080) begin
            n_fail++; $display("[TB] FAIL raw_hold: got %h expected 00000080", pending);
        end
        wb_valid = 1'b1; wb_rd = 5'd7;
        #1;
`ifdef SB_WB_BYPASS_EN
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL raw_bypass_ready: got %b expected 1", iss_ready);
        end
        step();
        wb_valid = 1'b0; iss_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'h0000_0100) begin
            n_fail++; $display("[TB] FAIL raw_bypass_pending: got %h expected 00000100", pending);
        end
`else
        n_checks++;
        if (iss_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL raw_wb_cycle_ready: got %b expected 0", iss_ready);
        end
        step();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'h0) begin
            n_fail++; $display("[TB] FAIL raw_cleared: got %h expected 0", pending);
        end
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL raw_ready_after: got %b expected 1", iss_ready);
        end
`endif
        n_checks++;
        if (wen !== 32'h0000_0080) begin
            n_fail++; $display("[TB] FAIL raw_wen7: got %h expected 00000080", wen);
        end
`ifndef SB_WB_BYPASS_EN
        step();
        iss_valid = 1'b0;
        #1;
`endif
        n_checks++;
        if (pending !== 32'h0000_0100) begin
            n_fail++; $display("[TB] FAIL raw_pending8: got %h expected 00000100", pending);
        end
        wb_valid = 1'b1; wb_rd = 5'd8;
        step();
        wb_valid = 1'b0;
        step();
        n_checks++;
        if (pending !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL raw_final: got pending %h err %b expected 0 0", pending, err);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        step();
        iss_valid = 1'b0;
        n_checks++;
        if (pending !== 32'h0) begin
            n_fail++; $display("[TB] FAIL zero_pending: got %h expected 0", pending);
        end
        wb_valid = 1'b1; wb_rd = 5'd0;
        step();
        wb_valid = 1'b0;
        n_checks++;
        if (wen !== 32'h0) begin
            n_fail++; $display("[TB] FAIL zero_wen: got %h expected 0", wen);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL zero_err: got %b expected 0", err);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        iss_rd24 = 5'd4; iss_rs124 = 5'd30; iss_rs224 = 5'd31;
        #1;
        n_checks++;
        if (iss_ready24 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL oor_ready: got %b expected 1", iss_ready24);
        end
        wb_valid24 = 1'b1; wb_rd24 = 5'd30;
        step();
        wb_valid24 = 1'b0;
        n_checks++;
        if (wen24 !== 24'h0) begin
            n_fail++; $display("[TB] FAIL oor_wen: got %h expected 0", wen24);
        end
        n_checks++;
        if (err24 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL oor_err: got %b expected 1", err24);
        end
        do_reset();
        iss_valid24 = 1'b1; iss_rd24 = 5'd25; iss_rs124 = 5'd0; iss_rs224 = 5'd0;
        step();
        iss_valid24 = 1'b0;
        n_checks++;
        if (err24 !== 1'b1 || pending24 !== 24'h0) begin
            n_fail++; $display("[TB] FAIL oor_issue: got err %b pending %h expected 1 0", err24, pending24);
        end
    endtask

    task automatic test_walk();
        logic [31:0] exp_wen;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            iss_valid = 1'b1; iss_rd = 5'(i); iss_rs1 = 5'd0; iss_rs2 = 5'd0;
            step();
        end
        iss_valid = 1'b0;
        n_checks++;
        if (pending !== 32'hFFFF_FFFE) begin
            n_fail++; $display("[TB] FAIL walk_all_pending: got %h expected fffffffe", pending);
        end
        for (int i = 0; i < 32; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i);
            exp_wen = (i == 0) ? 32'h0 : (32'h1 << i);
            step();
            n_checks++;
            if (wen !== exp_wen) begin
                n_fail++; $display("[TB] FAIL walk_wen[%0d]: got %h expected %h", i, wen, exp_wen);
            end
        end
        wb_valid = 1'b0;
        step();
        n_checks++;
        if (pending !== 32'h0 || wen !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL walk_end: got pending %h wen %h err %b expected 0 0 0", pending, wen, err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        n_checks++;
        if (pending !== 32'h0000_0208) begin
            n_fail++; $display("[TB] FAIL mid_pending_set: got %h expected 00000208", pending);
        end
        reset_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3;
        step();
        reset_n = 1'b1; wb_valid = 1'b0;
        iss_rs1 = 5'd3; iss_rs2 = 5'd9; iss_rd = 5'd1;
        #1;
        n_checks++;
        if (pending !== 32'h0 || wen !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_reset: got pending %h wen %h err %b expected 0 0 0", pending, wen, err);
        end
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mid_ready: got %b expected 1", iss_ready);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset_n = 1'b1;
        test_reset();
        test_unpended_wb();
        test_raw();
        test_zero_reg();
        test_out_of_range();
        test_walk();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
